// File: rtl/afifo_rd_pixel_stream_pkg.sv
// Shared definitions for the async-FIFO read-side pixel streamer:
// FSM state encoding, statistics width and a counter-width helper.
package pix_stream_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width needed to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/afifo_rd_pixel_stream_if.sv
// Framed pixel stream bundle (data plus frame/line markers).
//
// Handshake: a beat transfers on a rising clk edge where m_valid && m_ready.
// While m_valid is high and m_ready is low the master holds m_data and the
// markers stable; m_valid never drops without a transfer. m_sof/m_eol/m_eof
// carry meaning only while m_valid is high.
interface afifo_rd_pixel_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_sof;
    logic                  m_eol;
    logic                  m_eof;

    modport master (
        output m_valid,
        output m_data,
        output m_sof,
        output m_eol,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_sof,
        input  m_eol,
        input  m_eof,
        output m_ready
    );
endinterface

// File: rtl/afifo_rd_pixel_stream_buf.sv
// Small first-word-fall-through buffer that absorbs the FIFO read latency.
// The head entry is always visible on rd_data_o; occ_o reports how many
// entries are held. The writer guarantees it never pushes into a full buffer.
module pix_stream_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic                         rd_en_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic                  push, pop;

    // Pointer and occupancy bookkeeping; simultaneous push and pop cancel.
    always_comb begin
        push     = wr_en_i;
        pop      = rd_en_i && (occ_q != '0);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d    = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage and pointer registers; reset also clears the stored bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign valid_o   = (occ_q != '0);
    assign occ_o     = occ_q;

endmodule

// File: rtl/afifo_rd_pixel_stream.sv
// Drains the 8-bit read port of the async FIFO into a framed valid/ready
// pixel stream. Reads are credit-limited so bytes in flight plus bytes held
// never exceed the output buffer, and never run past one frame.
// Optional feature macro: PIX_STREAM_STATS_EN (underrun and frame counters).
module afifo_rd_pixel_stream
    import pix_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_rd_empty,
    afifo_rd_pixel_stream_if.master m,
    output logic [STAT_W-1:0]       stat_underrun,
    output logic [STAT_W-1:0]       stat_frames,
    output state_t                  dbg_state
);
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int IW    = $clog2(TOTAL + 1);
    localparam int CW    = cnt_w(IMG_WIDTH);
    localparam int RW    = cnt_w(IMG_HEIGHT);
    localparam int OW    = $clog2(BUF_DEPTH + 1);

    localparam logic [IW-1:0] TOTAL_V  = IW'(TOTAL);
    localparam logic [OW:0]   DEPTH_V  = (OW + 1)'(BUF_DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_t                state_q, state_d;
    logic [IW-1:0]         issued_q, issued_d;
    logic                  inflight_q;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [OW-1:0]         buf_occ;
    logic [OW:0]           pending;
    logic                  rd_en;
    logic                  hs;
    logic                  start_acc;
    logic                  sof_c, eol_c, eof_c;

    // Output buffer: written one cycle after each effective FIFO read.
    pix_stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (inflight_q),
        .wr_data_i (fifo_rd_data),
        .rd_en_i   (hs),
        .rd_data_o (buf_data),
        .valid_o   (buf_valid),
        .occ_o     (buf_occ)
    );

    // Handshake, start acceptance and position markers.
    always_comb begin
        hs        = buf_valid && m.m_ready;
        start_acc = (state_q == ST_IDLE) && start;
        sof_c     = (row_q == '0) && (col_q == '0);
        eol_c     = (col_q == COL_LAST);
        eof_c     = eol_c && (row_q == ROW_LAST);
    end

    // Read issue: only with a free credit and while the frame is not fully fetched.
    always_comb begin
        pending = {1'b0, buf_occ} + {{OW{1'b0}}, inflight_q};
        rd_en   = (state_q == ST_RUN) && !fifo_rd_empty
                  && (pending < DEPTH_V) && (issued_q < TOTAL_V);
    end

    // FSM next state and the per-frame issued-read counter.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    issued_d = '0;
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    issued_d = issued_q + 1'b1;
                end
                if (hs && eof_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Column/row position advances only on accepted pixels.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_acc) begin
            col_d = '0;
            row_d = '0;
        end else if (hs) begin
            if (eof_c) begin
                col_d = '0;
                row_d = '0;
            end else if (eol_c) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            inflight_q <= rd_en;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign dbg_state  = state_q;

    assign m.m_valid  = buf_valid;
    assign m.m_data   = buf_data;
    assign m.m_sof    = buf_valid && sof_c;
    assign m.m_eol    = buf_valid && eol_c;
    assign m.m_eof    = buf_valid && eof_c;

`ifdef PIX_STREAM_STATS_EN
    logic [STAT_W-1:0] und_q, und_d;
    logic [STAT_W-1:0] frm_q, frm_d;

    // Underrun counter saturates; frame counter wraps.
    always_comb begin
        und_d = und_q;
        frm_d = frm_q;
        if ((state_q == ST_RUN) && m.m_ready && !buf_valid && (und_q != '1)) begin
            und_d = und_q + 1'b1;
        end
        if (state_q == ST_DONE) begin
            frm_d = frm_q + 1'b1;
        end
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            und_q <= '0;
            frm_q <= '0;
        end else begin
            und_q <= und_d;
            frm_q <= frm_d;
        end
    end

    assign stat_underrun = und_q;
    assign stat_frames   = frm_q;
`else
    assign stat_underrun = '0;
    assign stat_frames   = '0;
`endif

endmodule

// File: tb/tb_afifo_rd_pixel_stream.sv
// Self-checking bench for afifo_rd_pixel_stream with a 4x2 image and a
// 4-entry buffer. A FIFO model feeds the DUT, a monitor records accepted
// pixels, and each scenario task compares them with a frame model.
module tb_afifo_rd_pixel_stream;
    import pix_stream_pkg::*;

    localparam int DW   = 8;
    localparam int IW   = 4;
    localparam int IH   = 2;
    localparam int BD   = 4;
    localparam int NPIX = IW * IH;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty;
    logic [15:0]   stat_underrun, stat_frames;
    state_t        dbg_state;

    afifo_rd_pixel_stream_if #(.DATA_WIDTH(DW)) pif();

    afifo_rd_pixel_stream #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .BUF_DEPTH  (BD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m             (pif.master),
        .stat_underrun (stat_underrun),
        .stat_frames   (stat_frames),
        .dbg_state     (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // FIFO model: bench writes fifo_mem/wr_idx, the read process owns rd_idx.
    logic [DW-1:0] fifo_mem [1024];
    int            wr_idx = 0;
    int            rd_idx = 0;
    assign fifo_rd_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_rd_empty) begin
            fifo_rd_data <= fifo_mem[rd_idx];
            rd_idx       <= rd_idx + 1;
        end
    end

    // Monitor: samples at the falling edge, between active edges.
    pix_t        obs [512];
    int          obs_n     = 0;
    int          cyc       = 0;
    int          rd_cnt    = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          eof_cyc   = 0;
    logic [15:0] und_model = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            und_model <= '0;
        end else begin
            if (pif.m_valid && pif.m_ready) begin
                obs[obs_n] <= {pif.m_data, pif.m_sof, pif.m_eol, pif.m_eof};
                obs_n      <= obs_n + 1;
                if (pif.m_eof) eof_cyc <= cyc;
            end
            if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (busy && pif.m_ready && !pif.m_valid) und_model <= und_model + 1'b1;
        end
    end

    // Scoreboard state
    logic [DW-1:0] exp_q[$];
    int            chk_cnt    = 0;
    int            pass_cnt   = 0;
    int            rdy_mode   = 0;
    int            frames_exp = 0;

    // Frame model: markers follow from the pixel's position in its frame.
    function automatic pix_t model_pix(input int k, input logic [DW-1:0] b);
        pix_t p;
        p.data = b;
        p.sof  = (k == 0);
        p.eol  = ((k % IW) == IW - 1);
        p.eof  = (k == NPIX - 1);
        return p;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       pif.m_ready = 1'b1;
            1:       pif.m_ready = 1'b0;
            default: pif.m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        fifo_mem[wr_idx] = b;
        wr_idx           = wr_idx + 1;
        exp_q.push_back(b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [15:0] exp_underrun();
`ifdef PIX_STREAM_STATS_EN
        return und_model;
`else
        return 16'h0;
`endif
    endfunction

    function automatic logic [15:0] exp_frames();
`ifdef PIX_STREAM_STATS_EN
        return 16'(frames_exp);
`else
        return 16'h0;
`endif
    endfunction

    // Scenario tasks
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        pif.m_ready = 1'b0;
        rdy_mode = 1;
        repeat (3) tick();
        chk_cnt++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
        else pass_cnt++;
        chk_cnt++;
        if ({busy, done, fifo_rd_en} !== 3'b000) $display("FAIL reset_ctrl got=%b exp=000", {busy, done, fifo_rd_en});
        else pass_cnt++;
        chk_cnt++;
        if ({pif.m_valid, pif.m_sof, pif.m_eol, pif.m_eof} !== 4'b0000)
            $display("FAIL reset_stream got=%b exp=0000", {pif.m_valid, pif.m_sof, pif.m_eol, pif.m_eof});
        else pass_cnt++;
        chk_cnt++;
        if (pif.m_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", pif.m_data);
        else pass_cnt++;
        chk_cnt++;
        if ({stat_underrun, stat_frames} !== 32'h0) $display("FAIL reset_stats got=%h exp=0", {stat_underrun, stat_frames});
        else pass_cnt++;
        rst = 1'b0;
        frames_exp = 0;
        tick();
    endtask

    task automatic test_basic_frame();
        int base = obs_n;
        int d0 = done_cnt;
        bit ok;
        pix_t e;
        for (int b = 0; b < NPIX; b++) push_byte(8'(b));
        rdy_mode = 0;
        pulse_start();
        wait_done(d0, 100, ok);
        chk_cnt++;
        if (!ok) $display("FAIL basic_done_timeout got=0 exp=1");
        else pass_cnt++;
        frames_exp++;
        chk_cnt++;
        if (obs_n - base !== NPIX) $display("FAIL basic_count got=%0d exp=%0d", obs_n - base, NPIX);
        else pass_cnt++;
        for (int i = 0; i < NPIX; i++) begin
            e = model_pix(i, exp_q.pop_front());
            chk_cnt++;
            if (obs[base + i] !== e) $display("FAIL basic_pix%0d got=%h exp=%h", i, obs[base + i], e);
            else pass_cnt++;
        end
        chk_cnt++;
        if (done_cyc !== eof_cyc + 1) $display("FAIL basic_done_latency got=%0d exp=%0d", done_cyc - eof_cyc, 1);
        else pass_cnt++;
        chk_cnt++;
        if ({busy, done, dbg_state} !== {2'b00, ST_IDLE}) $display("FAIL basic_after_done got=%b%b/%0d exp=00/0", busy, done, dbg_state);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int base = obs_n;
        int d0 = done_cnt;
        int r0 = rd_cnt;
        bit ok;
        bit held = 1'b1;
        logic [DW-1:0] first;
        pix_t e;
        for (int b = 0; b < NPIX; b++) push_byte(8'($urandom_range(0, 255)));
        first = exp_q[0];
        rdy_mode = 1;
        pulse_start();
        repeat (20) begin
            tick();
            if (pif.m_valid && (pif.m_data !== first)) held = 1'b0;
        end
        chk_cnt++;
        if (rd_cnt - r0 !== BD) $display("FAIL bp_reads got=%0d exp=%0d", rd_cnt - r0, BD);
        else pass_cnt++;
        chk_cnt++;
        if ({pif.m_valid, pif.m_data} !== {1'b1, first}) $display("FAIL bp_head got=%b/%h exp=1/%h", pif.m_valid, pif.m_data, first);
        else pass_cnt++;
        chk_cnt++;
        if (!held) $display("FAIL bp_stable got=0 exp=1");
        else pass_cnt++;
        rdy_mode = 0;
        wait_done(d0, 100, ok);
        frames_exp++;
        chk_cnt++;
        if (!ok || (obs_n - base !== NPIX)) $display("FAIL bp_count got=%0d exp=%0d", obs_n - base, NPIX);
        else pass_cnt++;
        for (int i = 0; i < NPIX; i++) begin
            e = model_pix(i, exp_q.pop_front());
            chk_cnt++;
            if (obs[base + i] !== e) $display("FAIL bp_pix%0d got=%h exp=%h", i, obs[base + i], e);
            else pass_cnt++;
        end
    endtask

    task automatic test_underrun();
        int base = obs_n;
        int d0 = done_cnt;
        logic [15:0] u0 = und_model;
        bit ok;
        pix_t e;
        rdy_mode = 0;
        pulse_start();
        for (int k = 0; k < NPIX; k++) begin
            push_byte(8'($urandom_range(0, 255)));
            repeat (5) tick();
        end
        wait_done(d0, 50, ok);
        frames_exp++;
        chk_cnt++;
        if (!ok || (obs_n - base !== NPIX)) $display("FAIL ur_count got=%0d exp=%0d", obs_n - base, NPIX);
        else pass_cnt++;
        for (int i = 0; i < NPIX; i++) begin
            e = model_pix(i, exp_q.pop_front());
            chk_cnt++;
            if (obs[base + i] !== e) $display("FAIL ur_pix%0d got=%h exp=%h", i, obs[base + i], e);
            else pass_cnt++;
        end
        chk_cnt++;
        if (und_model - u0 < 16'd8) $display("FAIL ur_gaps got=%0d exp>=8", und_model - u0);
        else pass_cnt++;
        chk_cnt++;
        if (stat_underrun !== exp_underrun()) $display("FAIL ur_stat got=%0d exp=%0d", stat_underrun, exp_underrun());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int base = obs_n;
        int d0 = done_cnt;
        bit ok;
        bit all_ok = 1'b1;
        pix_t e;
        for (int b = 0; b < 3 * NPIX; b++) push_byte(8'($urandom_range(0, 255)));
        rdy_mode = 2;
        for (int f = 0; f < 3; f++) begin
            pulse_start();
            wait_done(d0 + f, 200, ok);
            if (!ok) all_ok = 1'b0;
            frames_exp++;
        end
        chk_cnt++;
        if (!all_ok || (obs_n - base !== 3 * NPIX)) $display("FAIL b2b_count got=%0d exp=%0d", obs_n - base, 3 * NPIX);
        else pass_cnt++;
        for (int i = 0; i < 3 * NPIX; i++) begin
            e = model_pix(i % NPIX, exp_q.pop_front());
            chk_cnt++;
            if (obs[base + i] !== e) $display("FAIL b2b_pix%0d got=%h exp=%h", i, obs[base + i], e);
            else pass_cnt++;
        end
        chk_cnt++;
        if (stat_frames !== exp_frames()) $display("FAIL b2b_frames got=%0d exp=%0d", stat_frames, exp_frames());
        else pass_cnt++;
        chk_cnt++;
        if (stat_underrun !== exp_underrun()) $display("FAIL b2b_underrun got=%0d exp=%0d", stat_underrun, exp_underrun());
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int base = obs_n;
        int d0 = done_cnt;
        int r0 = rd_cnt;
        bit ok;
        pix_t e;
        for (int b = 0; b < NPIX; b++) push_byte(8'($urandom_range(0, 255)));
        push_byte(8'hA5);
        rdy_mode = 0;
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_done(d0, 100, ok);
        frames_exp++;
        repeat (15) tick();
        chk_cnt++;
        if (!ok || (obs_n - base !== NPIX)) $display("FAIL ign_count got=%0d exp=%0d", obs_n - base, NPIX);
        else pass_cnt++;
        chk_cnt++;
        if ((done_cnt - d0 !== 1) || (rd_cnt - r0 !== NPIX))
            $display("FAIL ign_frames got=%0d/%0d exp=1/%0d", done_cnt - d0, rd_cnt - r0, NPIX);
        else pass_cnt++;
        for (int i = 0; i < NPIX; i++) begin
            e = model_pix(i, exp_q.pop_front());
            chk_cnt++;
            if (obs[base + i] !== e) $display("FAIL ign_pix%0d got=%h exp=%h", i, obs[base + i], e);
            else pass_cnt++;
        end
        // The extra byte was never fetched; drop it so the FIFO starts clean.
        wr_idx = rd_idx;
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        int base = obs_n;
        int d0;
        bit ok = 1'b0;
        pix_t e;
        for (int b = 0; b < NPIX; b++) push_byte(8'($urandom_range(0, 255)));
        rdy_mode = 0;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            tick();
            if (obs_n - base >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (!ok || (obs_n - base !== 3)) $display("FAIL rstm_pixels got=%0d exp=3", obs_n - base);
        else pass_cnt++;
        chk_cnt++;
        if ({busy, done, fifo_rd_en, pif.m_valid, pif.m_sof, pif.m_eol, pif.m_eof} !== 7'b0)
            $display("FAIL rstm_ctrl got=%b exp=0000000", {busy, done, fifo_rd_en, pif.m_valid, pif.m_sof, pif.m_eol, pif.m_eof});
        else pass_cnt++;
        chk_cnt++;
        if ({dbg_state, pif.m_data, stat_underrun, stat_frames} !== {ST_IDLE, 8'h00, 32'h0})
            $display("FAIL rstm_values got=%0d/%h/%h exp=0/00/0", dbg_state, pif.m_data, {stat_underrun, stat_frames});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            e = model_pix(i, exp_q.pop_front());
            chk_cnt++;
            if (obs[base + i] !== e) $display("FAIL rstm_pix%0d got=%h exp=%h", i, obs[base + i], e);
            else pass_cnt++;
        end
        // FIFO is reset alongside the block: its remaining bytes are gone.
        wr_idx = rd_idx;
        exp_q.delete();
        frames_exp = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        base = obs_n;
        d0 = done_cnt;
        for (int b = 0; b < NPIX; b++) push_byte(8'($urandom_range(0, 255)));
        pulse_start();
        wait_done(d0, 100, ok);
        frames_exp++;
        chk_cnt++;
        if (!ok || (obs_n - base !== NPIX)) $display("FAIL rstm_refill_count got=%0d exp=%0d", obs_n - base, NPIX);
        else pass_cnt++;
        for (int i = 0; i < NPIX; i++) begin
            e = model_pix(i, exp_q.pop_front());
            chk_cnt++;
            if (obs[base + i] !== e) $display("FAIL rstm_refill_pix%0d got=%h exp=%h", i, obs[base + i], e);
            else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if (stat_frames !== exp_frames()) $display("FAIL rstm_frames got=%0d exp=%0d", stat_frames, exp_frames());
        else pass_cnt++;
    endtask

    // Test sequence and final report
    initial begin
        rst = 1'b1;
        start = 1'b0;
        pif.m_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_underrun();
        test_back_to_back();
        test_start_ignored();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
